// File: rtl/affine_buffer_pkg.sv
// Shared types and sizing for the affine ping-pong row buffer.
// Row geometry macros are shared with the upstream store stage.
`ifndef DATA_LEN_W
`define DATA_LEN_W 8
`endif
`ifndef AFFINE_ROWS
`define AFFINE_ROWS 64
`endif
`ifndef ROW_WORDS_N
`define ROW_WORDS_N 9
`endif

package affine_buffer_pkg;
  localparam int DATA_LEN  = `DATA_LEN_W;
  localparam int ROW_WORDS = `ROW_WORDS_N;
  localparam int ROW_W     = ROW_WORDS * DATA_LEN;
  localparam int DEPTH     = `AFFINE_ROWS;
  localparam int ADDR_W    = 9;
  localparam int ROW_IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAIN
  } bank_st_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_SHOW
  } rd_st_e;

  function automatic logic bank_writable(input bank_st_e s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

  function automatic logic bank_busy(input bank_st_e s);
    return (s == BANK_FULL) || (s == BANK_DRAIN);
  endfunction
endpackage

// File: rtl/affine_buffer_if.sv
// Write stream from the store stage plus valid/ready row replay to the next layer.
interface affine_buffer_if;
  import affine_buffer_pkg::*;

  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [ROW_W-1:0]     wr_data;
  logic                 wr_done;
  logic                 rd_ready;
  logic                 rd_valid;
  logic [ROW_IDX_W-1:0] rd_addr;
  logic [ROW_W-1:0]     rd_data;
  logic                 rd_last;
  logic [1:0]           full_cnt;
  logic                 overflow;

  modport master (
    output wr_en, wr_addr, wr_data, wr_done, rd_ready,
    input  rd_valid, rd_addr, rd_data, rd_last, full_cnt, overflow
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done, rd_ready,
    output rd_valid, rd_addr, rd_data, rd_last, full_cnt, overflow
  );
endinterface

// File: rtl/affine_buffer_ram.sv
// Simple dual-port RAM holding both banks; one-cycle registered read.
// Read data holds while re is low so the shown row stays stable under back-pressure.
module affine_bank_ram #(
  parameter int W  = 72,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/affine_buffer.sv
// Ping-pong row buffer: one bank fills from the store stage while the other replays in address order.
// First row valid two edges after commit, then 1 row / 2 cycles; rd_ready low freezes the shown row.
module affine_buffer
  import affine_buffer_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  affine_buffer_if.slave bus
);
  localparam logic [ADDR_W-1:0]    DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(DEPTH - 1);

  bank_st_e             bank_q [2];
  bank_st_e             bank_d [2];
  logic                 wb_q, wb_d, rb_q, rb_d;
  logic                 wr_done_q, wr_done_d;
  logic                 overflow_q, overflow_d;
  logic [1:0]           full_cnt_q, full_cnt_d;
  rd_st_e               rd_st_q, rd_st_d;
  logic [ROW_IDX_W-1:0] row_q, row_d, rd_addr_q, rd_addr_d;
  logic                 rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic                 in_range, wr_acc, wr_drop, commit, ram_re;
  logic [ROW_W-1:0]     ram_rdata;

  always_comb begin
    in_range  = bus.wr_addr < DEPTH_A;
    wr_acc    = bus.wr_en && in_range && bank_writable(bank_q[wb_q]);
    wr_drop   = bus.wr_en && in_range && !bank_writable(bank_q[wb_q]);
    commit    = bus.wr_done && !wr_done_q;
    wr_done_d = bus.wr_done;
  end

  always_comb begin
    bank_d     = bank_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    overflow_d = overflow_q;
    rd_st_d    = rd_st_q;
    row_d      = row_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    rd_last_d  = rd_last_q;
    ram_re     = 1'b0;

    if (wr_acc && bank_q[wb_q] == BANK_EMPTY) bank_d[wb_q] = BANK_FILLING;
    if (wr_drop) overflow_d = 1'b1;
    // A same-cycle write lands first; FULL simply overrides FILLING here.
    if (commit) begin
      if (bank_writable(bank_q[wb_q])) begin
        bank_d[wb_q] = BANK_FULL;
        wb_d         = !wb_q;
      end else begin
        overflow_d = 1'b1;
      end
    end

    case (rd_st_q)
      RD_IDLE: begin
        if (bank_q[rb_q] == BANK_FULL) begin
          bank_d[rb_q] = BANK_DRAIN;
          row_d        = '0;
          rd_st_d      = RD_FETCH;
        end
      end
      RD_FETCH: begin
        ram_re     = 1'b1;
        rd_valid_d = 1'b1;
        rd_addr_d  = row_q;
        rd_last_d  = (row_q == LAST_ROW);
        rd_st_d    = RD_SHOW;
      end
      RD_SHOW: begin
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rd_last_q) begin
            bank_d[rb_q] = BANK_EMPTY;
            rb_d         = !rb_q;
            rd_st_d      = RD_IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            rd_st_d = RD_FETCH;
          end
        end
      end
      default: rd_st_d = RD_IDLE;
    endcase

    full_cnt_d = {1'b0, bank_busy(bank_d[0])} + {1'b0, bank_busy(bank_d[1])};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q     <= '{BANK_EMPTY, BANK_EMPTY};
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      wr_done_q  <= 1'b0;
      overflow_q <= 1'b0;
      full_cnt_q <= '0;
      rd_st_q    <= RD_IDLE;
      row_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      wr_done_q  <= wr_done_d;
      overflow_q <= overflow_d;
      full_cnt_q <= full_cnt_d;
      rd_st_q    <= rd_st_d;
      row_q      <= row_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_last_q  <= rd_last_d;
    end
  end

  affine_bank_ram #(
    .W  (ROW_W),
    .AW (ROW_IDX_W + 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr ({wb_q, bus.wr_addr[ROW_IDX_W-1:0]}),
    .wdata (bus.wr_data),
    .re    (ram_re),
    .raddr ({rb_q, row_q}),
    .rdata (ram_rdata)
  );

  // RAM output is not reset; gating keeps rd_data at zero whenever nothing is shown.
  assign bus.rd_data  = rd_valid_q ? ram_rdata : '0;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.full_cnt = full_cnt_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_affine_buffer.sv
// Directed bench for affine_buffer: fill/commit/replay, back-pressure, ping-pong, overflow, reset.
module tb_affine_buffer;
  import affine_buffer_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  affine_buffer_if bus ();

  affine_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] row_of(input int b, input int r);
    logic [DATA_LEN-1:0] v;
    v = DATA_LEN'(b + r);
    return {ROW_WORDS{v}};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill(input int base);
    for (int a = 0; a < DEPTH; a++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = ADDR_W'(a);
      bus.wr_data = row_of(base, a);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic commit(input string tag, input int exp_cnt);
    bus.wr_done = 1'b1;
    @(negedge clk);
    chk(tag, bus.full_cnt, exp_cnt);
    bus.wr_done = 1'b0;
    @(negedge clk);
  endtask

  // Consume n rows; rows 0..63 come from base0, 64.. from base1. Optional stall on one row.
  task automatic drain(input int n, input int base0, input int base1, input int stall);
    int k = 0;
    int cyc = 0;
    logic [ROW_W-1:0]     snap_d;
    logic [ROW_IDX_W-1:0] snap_a;
    logic                 stable;
    bus.rd_ready = 1'b1;
    while (k < n && cyc < 2000) begin
      if (bus.rd_valid) begin
        if (k == stall) begin
          bus.rd_ready = 1'b0;
          snap_d = bus.rd_data;
          snap_a = bus.rd_addr;
          stable = 1'b1;
          repeat (10) begin
            @(negedge clk);
            if (bus.rd_data !== snap_d || bus.rd_addr !== snap_a || !bus.rd_valid) stable = 1'b0;
          end
          chk("bp_stable", stable, 1);
          bus.rd_ready = 1'b1;
        end
        chk("rd_addr", bus.rd_addr, k % DEPTH);
        chk("rd_data", bus.rd_data, row_of(k < DEPTH ? base0 : base1, k % DEPTH));
        chk("rd_last", bus.rd_last, (k % DEPTH) == DEPTH - 1);
        k++;
      end
      if (k < n) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("drain_count", k, n);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_done  = 1'b0;
    bus.rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_addr", bus.rd_addr, 0);
    chk("rst_data", bus.rd_data, 0);
    chk("rst_last", bus.rd_last, 0);
    chk("rst_full_cnt", bus.full_cnt, 0);
    chk("rst_overflow", bus.overflow, 0);

    // Single bank with commit-to-valid latency
    fill(0);
    chk("t1_fill_cnt", bus.full_cnt, 0);
    bus.wr_done = 1'b1;
    @(negedge clk);
    chk("t1_commit_cnt", bus.full_cnt, 1);
    chk("t1_valid_t0", bus.rd_valid, 0);
    bus.wr_done = 1'b0;
    @(negedge clk);
    chk("t1_valid_t1", bus.rd_valid, 0);
    @(negedge clk);
    chk("t1_valid_t2", bus.rd_valid, 1);
    drain(DEPTH, 0, 0, -1);
    repeat (4) @(negedge clk);
    chk("t1_end_cnt", bus.full_cnt, 0);
    chk("t1_end_valid", bus.rd_valid, 0);

    // Back-pressure on row 5
    fill(8'h40);
    commit("t2_commit_cnt", 1);
    drain(DEPTH, 8'h40, 0, 5);
    repeat (4) @(negedge clk);

    // Ping-pong: fill B while A drains
    fill(8'h10);
    commit("t3_commit_a", 1);
    fork
      begin
        fill(8'h80);
        commit("t3_full_two", 2);
      end
      drain(2 * DEPTH, 8'h10, 8'h80, -1);
    join
    repeat (4) @(negedge clk);
    chk("t3_overflow", bus.overflow, 0);
    chk("t3_end_cnt", bus.full_cnt, 0);

    // Overflow with both banks held
    bus.rd_ready = 1'b0;
    fill(8'h20);
    commit("t4_commit_a", 1);
    fill(8'h60);
    commit("t4_commit_b", 2);
    chk("t4_no_ovf_yet", bus.overflow, 0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = '0;
    bus.wr_data = {ROW_W{1'b1}};
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("t4_ovf_write", bus.overflow, 1);
    commit("t4_drop_commit", 2);
    chk("t4_ovf_sticky", bus.overflow, 1);
    drain(2 * DEPTH, 8'h20, 8'h60, -1);
    repeat (4) @(negedge clk);
    chk("t4_end_cnt", bus.full_cnt, 0);

    // Held wr_done with out-of-range writes
    do_reset();
    fill(8'h30);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 9'd100;
    bus.wr_data = {ROW_W{1'b1}};
    @(negedge clk);
    bus.rd_ready = 1'b0;
    bus.wr_done  = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_one_commit", bus.full_cnt, 1);
    chk("t5_overflow", bus.overflow, 0);
    bus.wr_done = 1'b0;
    bus.wr_en   = 1'b0;
    drain(DEPTH, 8'h30, 0, -1);
    repeat (6) @(negedge clk);
    chk("t5_end_cnt", bus.full_cnt, 0);
    chk("t5_end_valid", bus.rd_valid, 0);
    chk("t5_end_ovf", bus.overflow, 0);

    // Reset mid-drain at row 30
    fill(8'h05);
    commit("t6_commit", 1);
    drain(30, 8'h05, 0, -1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_at_row30", bus.rd_addr, 30);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.rd_valid, 0);
    chk("t6_rst_addr", bus.rd_addr, 0);
    chk("t6_rst_data", bus.rd_data, 0);
    chk("t6_rst_last", bus.rd_last, 0);
    chk("t6_rst_cnt", bus.full_cnt, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(8'h50);
    commit("t6_refill_commit", 1);
    drain(DEPTH, 8'h50, 0, -1);
    repeat (4) @(negedge clk);
    chk("t6_end_cnt", bus.full_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
